// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

    // Default operand/result width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: waiting, consuming bits, holding a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: difference and borrow-out from x, y and borrow-in.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module serial_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x, or when x equals y and a borrow is pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: x - y mod 2^WIDTH, operands arrive LSB first, one bit per qualified cycle.
// Latency: result registered on the edge that consumes the WIDTH-th valid bit; done visible the cycle after.
// Backpressure: bit_valid=0 stalls the shift; done is held until ack; start/ack outside their states are ignored.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             x,
    input  logic             y,
    input  logic             bit_valid,
    input  logic             ack,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             borrow;
    // Holds the WIDTH-1 most recent difference bits; the newest bit is
    // appended on top, so after WIDTH bits {d, sr} is the full result.
    logic [WIDTH-2:0] sr;

    logic             cell_d;
    logic             cell_b;
    logic [WIDTH-1:0] sr_cat;

    serial_sub_cell u_cell (
        .x    (x),
        .y    (y),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_b)
    );

    assign sr_cat = {cell_d, sr};

    // Controller, datapath state and registered outputs in one process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            diff   <= '0;
            bout   <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
            borrow <= 1'b0;
            sr     <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        borrow <= 1'b0;
                        sr     <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        sr     <= sr_cat[WIDTH-1:1];
                        borrow <= cell_b;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_BIT) begin
                            // Final bit: publish the result and hand off.
                            diff  <= sr_cat;
                            bout  <= cell_b;
`ifdef SERIAL_SUB_OVF_EN
                            // Signs of operands differ and result sign differs from minuend.
                            ovf   <= (x != y) && (cell_d != x);
`endif
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        done <= 1'b0;
                        if (start) begin
                            // Back-to-back: skip IDLE and begin the next operand pair.
                            state  <= SHIFT;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            borrow <= 1'b0;
                            sr     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): directed cases plus randomized operands.
// Latency: checks done rises exactly on the cycle after the last valid bit, accounting for stalls.
// Backpressure: exercises bit_valid stalls, delayed ack, and ack+start back-to-back.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic       x;
    logic       y;
    logic       bit_valid;
    logic       ack;
    logic [7:0] diff;
    logic       bout;
    logic       done;
    logic       busy;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int errors;
    int checks;

    // Reference result currently expected on the outputs.
    logic [7:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;

    serial_sub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x         (x),
        .y         (y),
        .bit_valid (bit_valid),
        .ack       (ack),
        .diff      (diff),
        .bout      (bout),
        .done      (done),
        .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: plain integer arithmetic on whole operands.
    task automatic model(input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        sd = sa - sb;
        exp_diff = 8'((ua - ub + 256) % 256);
        exp_bout = (ua < ub);
        exp_ovf  = (sd > 127) || (sd < -128);
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        chk({tag, "_bout"}, 32'(bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // Run one subtraction. stall_at: bit index before which bit_valid drops for stall_len cycles.
    // via_b2b: SHIFT was already entered through ack+start, so no start pulse is issued.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall_at,
                          input int stall_len, input bit via_b2b, input string tag);
        logic [7:0] old_diff;
        logic       old_bout;
        old_diff = exp_diff;
        old_bout = exp_bout;
        if (!via_b2b) begin
            start = 1'b1;
            ack   = 1'($urandom);
            tick();
            start = 1'b0;
            ack   = 1'b0;
            chk({tag, "_st_busy"}, 32'(busy), 32'd1);
            chk({tag, "_st_done"}, 32'(done), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bit_valid = 1'b0;
                    x         = 1'($urandom);
                    y         = 1'($urandom);
                    start     = 1'($urandom);
                    ack       = 1'($urandom);
                    tick();
                    chk({tag, "_stall_busy"}, 32'(busy), 32'd1);
                    chk({tag, "_stall_done"}, 32'(done), 32'd0);
                    chk({tag, "_stall_diff"}, 32'(diff), 32'(old_diff));
                end
            end
            bit_valid = 1'b1;
            x         = a[i];
            y         = b[i];
            start     = 1'($urandom);
            ack       = 1'($urandom);
            tick();
            if (i < 7) begin
                chk({tag, "_sh_busy"}, 32'(busy), 32'd1);
                chk({tag, "_sh_done"}, 32'(done), 32'd0);
                chk({tag, "_sh_diff"}, 32'(diff), 32'(old_diff));
                chk({tag, "_sh_bout"}, 32'(bout), 32'(old_bout));
            end
        end
        bit_valid = 1'b0;
        start     = 1'b0;
        ack       = 1'b0;
        model(a, b);
        chk_result(tag);
    endtask

    // Hold in DONE for wait_cycles (start without ack must be ignored), then ack.
    task automatic finish_op(input int wait_cycles, input bit b2b, input string tag);
        for (int w = 0; w < wait_cycles; w++) begin
            start     = 1'($urandom);
            bit_valid = 1'($urandom);
            tick();
            chk_result({tag, "_hold"});
        end
        ack   = 1'b1;
        start = b2b;
        tick();
        ack       = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        chk({tag, "_ack_done"}, 32'(done), 32'd0);
        chk({tag, "_ack_busy"}, 32'(busy), 32'(b2b));
        chk({tag, "_ack_diff"}, 32'(diff), 32'(exp_diff));
    endtask

    initial begin
        bit b2b;
        logic [7:0] ra, rb;
        int st_at, st_len;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        start     = 1'b1;
        ack       = 1'b1;
        bit_valid = 1'b1;
        x         = 1'b1;
        y         = 1'b0;
        exp_diff  = 8'h00;
        exp_bout  = 1'b0;
        exp_ovf   = 1'b0;
        tick();
        tick();
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst       = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        x         = 1'b0;

        // ack while idle is ignored
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack_busy", 32'(busy), 32'd0);
        chk("idle_ack_done", 32'(done), 32'd0);

        // 0x5A - 0x33, continuous bits
        run_op(8'h5A, 8'h33, -1, 0, 1'b0, "c1");
        chk("c1_const_diff", 32'(diff), 32'h27);
        chk("c1_const_bout", 32'(bout), 32'd0);
        finish_op(2, 1'b0, "c1");

        // 0x10 - 0x20, borrow out
        run_op(8'h10, 8'h20, -1, 0, 1'b0, "c2");
        chk("c2_const_diff", 32'(diff), 32'hF0);
        chk("c2_const_bout", 32'(bout), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        chk("c2_const_ovf", 32'(ovf), 32'd0);
`endif
        finish_op(0, 1'b0, "c2");

        // 0x80 - 0x01, signed overflow
        run_op(8'h80, 8'h01, -1, 0, 1'b0, "c3");
        chk("c3_const_diff", 32'(diff), 32'h7F);
        chk("c3_const_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("c3_const_ovf", 32'(ovf), 32'd1);
`endif
        finish_op(1, 1'b0, "c3");

        // 0x5A - 0x33 with a 3-cycle stall after bit 4
        run_op(8'h5A, 8'h33, 4, 3, 1'b0, "c4");
        chk("c4_const_diff", 32'(diff), 32'h27);
        finish_op(0, 1'b0, "c4");

        // reset after 4 valid bits
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            x         = 1'($urandom);
            y         = 1'($urandom);
            tick();
        end
        rst   = 1'b1;
        start = 1'b1;
        ack   = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        ack       = 1'b0;
        bit_valid = 1'b0;
        exp_diff  = 8'h00;
        exp_bout  = 1'b0;
        exp_ovf   = 1'b0;
        chk("c5_rst_busy", 32'(busy), 32'd0);
        chk("c5_rst_done", 32'(done), 32'd0);
        chk("c5_rst_diff", 32'(diff), 32'd0);
        chk("c5_rst_bout", 32'(bout), 32'd0);
        run_op(8'hFF, 8'hFF, -1, 0, 1'b0, "c5");
        chk("c5_const_diff", 32'(diff), 32'h00);
        chk("c5_const_bout", 32'(bout), 32'd0);
        finish_op(0, 1'b0, "c5");

        // back-to-back through ack+start
        run_op(8'h5A, 8'h33, -1, 0, 1'b0, "c6a");
        finish_op(0, 1'b1, "c6a");
        run_op(8'h03, 8'h05, -1, 0, 1'b1, "c6b");
        chk("c6b_const_diff", 32'(diff), 32'hFE);
        chk("c6b_const_bout", 32'(bout), 32'd1);
        finish_op(0, 1'b0, "c6b");

        // randomized operands, stalls, ack delays and back-to-back chaining
        b2b = 1'b0;
        for (int n = 0; n < 24; n++) begin
            ra     = 8'($urandom);
            rb     = 8'($urandom);
            st_at  = $urandom_range(0, 8);
            st_len = $urandom_range(0, 3);
            run_op(ra, rb, st_at, st_len, b2b, "rnd");
            b2b = 1'($urandom);
            finish_op($urandom_range(0, 2), b2b, "rnd");
        end
        if (b2b) begin
            run_op(8'($urandom), 8'($urandom), -1, 0, 1'b1, "rnd_tail");
            finish_op(0, 1'b0, "rnd_tail");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
